// File: rtl/ctl_fp_mul_arbiter.sv
// ctl_fp_mul_arbiter: round-robin sharing of one pipelined signed Q-format 32x32 multiplier.
// Define CTL_FP_MUL_SAT_EN to saturate rsp_data on overflow; otherwise the result wraps.
module ctl_fp_mul_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ID_W      = 2,
    parameter int FRAC_BITS = 24,
    parameter int MUL_LAT   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic                  rsp_ov,
    output logic [N_REQ-1:0]      busy
);

    // First eligible requester at or after start, wrapping; MSB of the result flags a hit.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] elig,
                                              input logic [ID_W-1:0]  start);
        logic [ID_W:0] res;
        int            cand;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = int'(start) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end else begin
                cand = cand;
            end
            if (elig[cand]) begin
                res = {1'b1, ID_W'(cand)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // q is the product already shifted right by FRAC_BITS, so q[63:31] must be a pure sign extension.
    function automatic logic q_overflow(input logic [63:0] q);
        return ~((&q[63:31]) | ~(|q[63:31]));
    endfunction

    logic [ID_W:0]        pick_s;
    logic                 gnt_found_s;
    logic [ID_W-1:0]      gnt_idx_s;
    logic                 accept_s;
    logic [N_REQ-1:0]     eligible_s;
    logic [N_REQ-1:0]     gnt_onehot_s;
    logic [N_REQ-1:0]     clear_s;
    logic [31:0]          op_a_s;
    logic [31:0]          op_b_s;
    logic signed [63:0]   q_s;
    logic                 ov_s;
    logic [31:0]          data_s;
    logic [ID_W-1:0]      ptr_r;
    logic [N_REQ-1:0]     busy_r;

    logic                 in_valid_s  [MUL_LAT];
    logic [ID_W-1:0]      in_id_s     [MUL_LAT];
    logic [31:0]          in_data_s   [MUL_LAT];
    logic                 in_ov_s     [MUL_LAT];
    logic                 pipe_valid_r[MUL_LAT];
    logic [ID_W-1:0]      pipe_id_r   [MUL_LAT];
    logic [31:0]          pipe_data_r [MUL_LAT];
    logic                 pipe_ov_r   [MUL_LAT];

    // Arbitration: round-robin grant among valid, non-busy requesters; nothing granted in reset.
    always_comb begin
        eligible_s   = req_valid & ~busy_r;
        pick_s       = rr_pick(eligible_s, ptr_r);
        gnt_found_s  = pick_s[ID_W];
        gnt_idx_s    = pick_s[ID_W-1:0];
        accept_s     = gnt_found_s & ~rst;
        gnt_onehot_s = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx_s;
        req_ready    = accept_s ? gnt_onehot_s : '0;
        clear_s      = rsp_valid ? ({{(N_REQ-1){1'b0}}, 1'b1} << rsp_id) : '0;
        op_a_s       = req_a[{gnt_idx_s, 5'b00000} +: 32];
        op_b_s       = req_b[{gnt_idx_s, 5'b00000} +: 32];
    end

    // Multiply the granted operands and reduce the product to the 32-bit Q result.
    always_comb begin
        q_s  = ($signed({{32{op_a_s[31]}}, op_a_s}) * $signed({{32{op_b_s[31]}}, op_b_s})) >>> FRAC_BITS;
        ov_s = q_overflow(q_s);
`ifdef CTL_FP_MUL_SAT_EN
        if (ov_s) begin
            data_s = q_s[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            data_s = q_s[31:0];
        end
`else
        data_s = q_s[31:0];
`endif
    end

    // Stage inputs: stage 0 takes the accepted operation, later stages take their predecessor.
    always_comb begin
        in_valid_s[0] = accept_s;
        in_id_s[0]    = gnt_idx_s;
        in_data_s[0]  = data_s;
        in_ov_s[0]    = ov_s;
        for (int k = 1; k < MUL_LAT; k++) begin
            in_valid_s[k] = pipe_valid_r[k-1];
            in_id_s[k]    = pipe_id_r[k-1];
            in_data_s[k]  = pipe_data_r[k-1];
            in_ov_s[k]    = pipe_ov_r[k-1];
        end
    end

    // Result pipeline; payload only moves with a valid so the last stage holds between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                pipe_valid_r[k] <= 1'b0;
                pipe_id_r[k]    <= '0;
                pipe_data_r[k]  <= 32'h0000_0000;
                pipe_ov_r[k]    <= 1'b0;
            end
        end else begin
            for (int k = 0; k < MUL_LAT; k++) begin
                pipe_valid_r[k] <= in_valid_s[k];
                if (in_valid_s[k]) begin
                    pipe_id_r[k]   <= in_id_s[k];
                    pipe_data_r[k] <= in_data_s[k];
                    pipe_ov_r[k]   <= in_ov_s[k];
                end
            end
        end
    end

    // Round-robin pointer and per-requester in-flight flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r  <= '0;
            busy_r <= '0;
        end else begin
            busy_r <= (busy_r & ~clear_s) | req_ready;
            if (accept_s) begin
                ptr_r <= (gnt_idx_s == ID_W'(N_REQ - 1)) ? '0 : gnt_idx_s + ID_W'(1);
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    assign rsp_valid = pipe_valid_r[MUL_LAT-1];
    assign rsp_id    = pipe_id_r[MUL_LAT-1];
    assign rsp_data  = pipe_data_r[MUL_LAT-1];
    assign rsp_ov    = pipe_ov_r[MUL_LAT-1];
    assign busy      = busy_r;

endmodule

// File: tb/tb_ctl_fp_mul_arbiter.sv
// Self-checking bench for ctl_fp_mul_arbiter: directed vectors plus randomized traffic
// checked every cycle against a transaction-level model (grant order, due times, in-flight windows).
module tb_ctl_fp_mul_arbiter;
    localparam int N_REQ     = 4;
    localparam int ID_W      = 2;
    localparam int FRAC_BITS = 24;
    localparam int MUL_LAT   = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N_REQ-1:0]    req_valid = '0;
    logic [32*N_REQ-1:0] req_a = '0;
    logic [32*N_REQ-1:0] req_b = '0;
    logic [N_REQ-1:0]    req_ready;
    logic                rsp_valid;
    logic [ID_W-1:0]     rsp_id;
    logic [31:0]         rsp_data;
    logic                rsp_ov;
    logic [N_REQ-1:0]    busy;

    int tests_run    = 0;
    int tests_failed = 0;

    ctl_fp_mul_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .FRAC_BITS(FRAC_BITS), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ov(rsp_ov), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
        logic        ov;
    } rsp_t;

    rsp_t        exp_q[$];
    int          cyc;
    int          ptr_m;
    int          acc_at [N_REQ];
    int          free_at[N_REQ];
    logic [ID_W-1:0] held_id;
    logic [31:0] held_data;
    logic        held_ov;

    logic [N_REQ-1:0] last_ready;
    int          last_rsp_id;
    logic [31:0] last_rsp_data;
    logic        last_rsp_ov;
    int          rsp_seen;

    function automatic void model_mul(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] d, output logic ov);
        longint p;
        longint hi;
        p  = longint'($signed(a)) * longint'($signed(b));
        hi = p >>> (FRAC_BITS + 31);
        ov = !(hi == 0 || hi == -1);
        d  = 32'(p >>> FRAC_BITS);
`ifdef CTL_FP_MUL_SAT_EN
        if (ov) d = (p > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    endfunction

    task automatic model_reset();
        ptr_m = 0;
        for (int i = 0; i < N_REQ; i++) begin
            acc_at[i]  = -100;
            free_at[i] = 0;
        end
        exp_q.delete();
        held_id   = '0;
        held_data = 32'h0;
        held_ov   = 1'b0;
        cyc       = 0;
    endtask

    // One clock cycle with the currently driven inputs: check at negedge, advance model, cross posedge.
    task automatic step();
        logic [N_REQ-1:0] exp_ready;
        logic [N_REQ-1:0] exp_busy;
        int               g;
        int               cand;
        rsp_t             e;
        logic [31:0]      d;
        logic             ov;
        logic             ev;
        @(negedge clk);
        exp_ready = '0;
        exp_busy  = '0;
        g = -1;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (ptr_m + k) % N_REQ;
            if (g < 0 && req_valid[cand] && cyc >= free_at[cand]) g = cand;
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        for (int i = 0; i < N_REQ; i++)
            exp_busy[i] = (cyc >= acc_at[i] + 1) && (cyc <= acc_at[i] + MUL_LAT);
        tests_run++;
        if (req_ready !== exp_ready) begin
            tests_failed++;
            $display("FAIL ready cyc=%0d got=%b expected=%b", cyc, req_ready, exp_ready);
        end
        tests_run++;
        if (busy !== exp_busy) begin
            tests_failed++;
            $display("FAIL busy cyc=%0d got=%b expected=%b", cyc, busy, exp_busy);
        end
        ev = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            ev = 1'b1;
            held_id   = ID_W'(e.id);
            held_data = e.data;
            held_ov   = e.ov;
        end
        tests_run++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_ov} !== {ev, held_id, held_data, held_ov}) begin
            tests_failed++;
            $display("FAIL rsp cyc=%0d got v=%b id=%0d data=%h ov=%b expected v=%b id=%0d data=%h ov=%b",
                     cyc, rsp_valid, rsp_id, rsp_data, rsp_ov, ev, held_id, held_data, held_ov);
        end
        last_ready = req_ready;
        if (rsp_valid === 1'b1) begin
            rsp_seen++;
            last_rsp_id   = int'(rsp_id);
            last_rsp_data = rsp_data;
            last_rsp_ov   = rsp_ov;
        end
        if (g >= 0) begin
            model_mul(req_a[g*32 +: 32], req_b[g*32 +: 32], d, ov);
            exp_q.push_back('{due: cyc + MUL_LAT, id: g, data: d, ov: ov});
            acc_at[g]  = cyc;
            free_at[g] = cyc + MUL_LAT + 1;
            ptr_m      = (g + 1) % N_REQ;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? $urandom : (32'($signed($urandom_range(0, 2048)) - 1024) <<< 20);
            req_b[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? $urandom : (32'($signed($urandom_range(0, 2048)) - 1024) <<< 20);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        randomize_ops();
        @(negedge clk);
        tests_run++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_ov, busy} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs got ready=%b v=%b id=%0d data=%h ov=%b busy=%b expected all zero",
                     req_ready, rsp_valid, rsp_id, rsp_data, rsp_ov, busy);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_vectors();
        logic [1:0]  vid  [5] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0};
        logic [31:0] va   [5] = '{32'h0180_0000, 32'hFF00_0000, 32'h6400_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] vb   [5] = '{32'h0200_0000, 32'h0080_0000, 32'h0200_0000, 32'h8000_0000, 32'h0200_0000};
`ifdef CTL_FP_MUL_SAT_EN
        logic [31:0] vd   [5] = '{32'h0300_0000, 32'hFF80_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
`else
        logic [31:0] vd   [5] = '{32'h0300_0000, 32'hFF80_0000, 32'hC800_0000, 32'h0000_0000, 32'h0000_0000};
`endif
        logic        vov  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int          seen0;
        for (int t = 0; t < 5; t++) begin
            randomize_ops();
            req_a[vid[t]*32 +: 32] = va[t];
            req_b[vid[t]*32 +: 32] = vb[t];
            req_valid = '0;
            req_valid[vid[t]] = 1'b1;
            seen0 = rsp_seen;
            step();
            idle(MUL_LAT + 1);
            tests_run++;
            if (rsp_seen != seen0 + 1 || last_rsp_id != int'(vid[t]) || last_rsp_data !== vd[t] || last_rsp_ov !== vov[t]) begin
                tests_failed++;
                $display("FAIL vector%0d got n=%0d id=%0d data=%h ov=%b expected n=1 id=%0d data=%h ov=%b",
                         t, rsp_seen - seen0, last_rsp_id, last_rsp_data, last_rsp_ov, vid[t], vd[t], vov[t]);
            end
        end
    endtask

    task automatic test_all_requesters();
        logic [N_REQ-1:0] grants [6];
        int               ids    [6];
        logic [N_REQ-1:0] exp_g  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        test_reset();
        req_valid = 4'hF;
        for (int c = 0; c < 6; c++) begin
            randomize_ops();
            last_rsp_id = -1;
            step();
            grants[c] = last_ready;
            ids[c]    = last_rsp_id;
        end
        for (int c = 0; c < 6; c++) begin
            tests_run++;
            if (grants[c] !== exp_g[c]) begin
                tests_failed++;
                $display("FAIL rr_grant cyc=%0d got=%b expected=%b", c, grants[c], exp_g[c]);
            end
        end
        for (int c = 2; c < 6; c++) begin
            tests_run++;
            if (ids[c] != c - 2) begin
                tests_failed++;
                $display("FAIL rr_rsp_id cyc=%0d got=%0d expected=%0d", c, ids[c], c - 2);
            end
        end
        for (int c = 0; c < 20; c++) begin
            randomize_ops();
            step();
        end
        idle(MUL_LAT + 1);
    endtask

    task automatic test_reset_midop();
        int seen0;
        randomize_ops();
        req_valid = 4'b1000;
        step();
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        tests_run++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_ov, busy} !== '0) begin
            tests_failed++;
            $display("FAIL midop_reset got ready=%b v=%b id=%0d data=%h ov=%b busy=%b expected all zero",
                     req_ready, rsp_valid, rsp_id, rsp_data, rsp_ov, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        seen0 = rsp_seen;
        idle(5);
        tests_run++;
        if (rsp_seen != seen0) begin
            tests_failed++;
            $display("FAIL midop_no_rsp got=%0d responses expected=0", rsp_seen - seen0);
        end
        req_valid = 4'hF;
        randomize_ops();
        step();
        tests_run++;
        if (last_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL midop_ptr got=%b expected=0001", last_ready);
        end
        idle(MUL_LAT + 2);
    endtask

    task automatic test_single_stream();
        int accepts;
        int seen0;
        accepts = 0;
        seen0 = rsp_seen;
        req_valid = 4'b0001;
        for (int c = 0; c < 9; c++) begin
            randomize_ops();
            step();
            if (last_ready[0] === 1'b1) accepts++;
        end
        req_valid = '0;
        tests_run++;
        if (accepts != 3 || rsp_seen - seen0 != 3) begin
            tests_failed++;
            $display("FAIL single_stream got accepts=%0d rsps=%0d expected 3 and 3", accepts, rsp_seen - seen0);
        end
        idle(MUL_LAT + 1);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req_valid = N_REQ'($urandom);
            randomize_ops();
            step();
        end
        idle(MUL_LAT + 2);
    endtask

    initial begin
        rsp_seen = 0;
        last_rsp_id = -1;
        last_rsp_data = 32'h0;
        last_rsp_ov = 1'b0;
        last_ready = '0;
        model_reset();
        #1;
        test_reset();
        test_vectors();
        test_all_requesters();
        test_reset_midop();
        test_single_stream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
